// File: rtl/mem_write_buffer_if.sv
// mem_write_buffer_if: upstream (cache) and downstream (arbiter) bus bundle for the posted-write buffer
`ifndef MEM_ADDR_BITS
`define MEM_ADDR_BITS 32
`endif
`ifndef MEM_DATA_BITS
`define MEM_DATA_BITS 128
`endif
interface mem_write_buffer_if #(
  parameter int ADDR_BITS = `MEM_ADDR_BITS,
  parameter int DATA_BITS = `MEM_DATA_BITS
);
  logic                   in_req_valid, in_req_ready, in_req_rw;
  logic [ADDR_BITS-1:0]   in_req_addr;
  logic                   in_req_data_valid, in_req_data_ready;
  logic [DATA_BITS-1:0]   in_req_data_bits;
  logic [DATA_BITS/8-1:0] in_req_data_mask;
  logic                   in_resp_valid;
  logic [DATA_BITS-1:0]   in_resp_data;
  logic                   out_req_valid, out_req_ready, out_req_rw;
  logic [ADDR_BITS-1:0]   out_req_addr;
  logic                   out_req_data_valid, out_req_data_ready;
  logic [DATA_BITS-1:0]   out_req_data_bits;
  logic [DATA_BITS/8-1:0] out_req_data_mask;
  logic                   out_resp_valid;
  logic [DATA_BITS-1:0]   out_resp_data;
  modport slave (
    input  in_req_valid, in_req_rw, in_req_addr, in_req_data_valid, in_req_data_bits, in_req_data_mask,
    output in_req_ready, in_req_data_ready, in_resp_valid, in_resp_data,
    output out_req_valid, out_req_rw, out_req_addr, out_req_data_valid, out_req_data_bits, out_req_data_mask,
    input  out_req_ready, out_req_data_ready, out_resp_valid, out_resp_data
  );
  modport master (
    output in_req_valid, in_req_rw, in_req_addr, in_req_data_valid, in_req_data_bits, in_req_data_mask,
    input  in_req_ready, in_req_data_ready, in_resp_valid, in_resp_data,
    input  out_req_valid, out_req_rw, out_req_addr, out_req_data_valid, out_req_data_bits, out_req_data_mask,
    output out_req_ready, out_req_data_ready, out_resp_valid, out_resp_data
  );
endinterface

// File: rtl/mem_write_buffer.sv
// mem_write_buffer: posted-write FIFO with RAW-safe read forwarding and a single downstream issue FSM
`ifndef MEM_ADDR_BITS
`define MEM_ADDR_BITS 32
`endif
`ifndef MEM_DATA_BITS
`define MEM_DATA_BITS 128
`endif
module mem_write_buffer #(
  parameter int DEPTH      = 4,
  parameter int ADDR_BITS  = `MEM_ADDR_BITS,
  parameter int DATA_BITS  = `MEM_DATA_BITS,
  parameter int READ_BEATS = 4
) (
  input  logic                clk,
  input  logic                reset,
  mem_write_buffer_if.slave   bus,
  output logic                wb_empty
);
  localparam int MW = DATA_BITS / 8;
  localparam int PW = $clog2(DEPTH);
  localparam int BW = $clog2(READ_BEATS) + 1;
  localparam logic [PW:0] FULL = (PW+1)'(DEPTH);
  typedef enum logic [2:0] {IDLE, RD_CMD, RD_WAIT, WR_CMD, WR_DATA} state_t;
  state_t               r_state;
  logic [ADDR_BITS-1:0] r_addr [DEPTH];
  logic [DATA_BITS-1:0] r_data [DEPTH];
  logic [MW-1:0]        r_mask [DEPTH];
  logic [DEPTH-1:0]     r_vld;
  logic [PW-1:0]        r_head, r_tail;
  logic [PW:0]          r_count;
  logic [BW-1:0]        r_beat;
  logic [ADDR_BITS-1:0] r_rd_addr;
  logic                 w_conflict, w_wr_acc, w_rd_acc, w_pop;
  // a read must not pass any buffered write to the same address, including the one in flight
  always_comb begin
    w_conflict = 1'b0;
    for (int i = 0; i < DEPTH; i++)
      w_conflict = w_conflict | (r_vld[i] & (r_addr[i] == bus.in_req_addr));
  end
  assign w_wr_acc = reset & bus.in_req_valid & bus.in_req_rw & bus.in_req_data_valid & (r_count < FULL);
  assign w_rd_acc = reset & bus.in_req_valid & ~bus.in_req_rw & (r_state == IDLE) & ~w_conflict;
  assign w_pop    = (r_state == WR_DATA) & bus.out_req_data_ready;
  assign bus.in_req_ready       = w_wr_acc | w_rd_acc;
  assign bus.in_req_data_ready  = w_wr_acc;
  assign bus.in_resp_valid      = (r_state == RD_WAIT) & bus.out_resp_valid;
  assign bus.in_resp_data       = bus.out_resp_data;
  assign bus.out_req_valid      = (r_state == RD_CMD) | (r_state == WR_CMD);
  assign bus.out_req_rw         = r_state == WR_CMD;
  assign bus.out_req_addr       = (r_state == RD_CMD) ? r_rd_addr : (r_state == WR_CMD) ? r_addr[r_head] : '0;
  assign bus.out_req_data_valid = r_state == WR_DATA;
  assign bus.out_req_data_bits  = (r_state == WR_DATA) ? r_data[r_head] : '0;
  assign bus.out_req_data_mask  = (r_state == WR_DATA) ? r_mask[r_head] : '0;
  assign wb_empty               = reset & (r_count == '0) & (r_state == IDLE);
  // FIFO storage: push at tail on write accept, pop head once its data beat is taken downstream
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_addr[i] <= '0;
        r_data[i] <= '0;
        r_mask[i] <= '0;
      end
      r_vld   <= '0;
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
    end else begin
      if (w_wr_acc) begin
        r_addr[r_tail] <= bus.in_req_addr;
        r_data[r_tail] <= bus.in_req_data_bits;
        r_mask[r_tail] <= bus.in_req_data_mask;
        r_vld[r_tail]  <= 1'b1;
        r_tail         <= r_tail + 1'b1;
      end
      if (w_pop) begin
        r_vld[r_head] <= 1'b0;
        r_head        <= r_head + 1'b1;
      end
      r_count <= r_count + {{PW{1'b0}}, w_wr_acc} - {{PW{1'b0}}, w_pop};
    end
  end
  // downstream issue FSM: one transaction at a time, an accepted read goes ahead of draining
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state   <= IDLE;
      r_beat    <= '0;
      r_rd_addr <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_rd_acc) begin
            r_state   <= RD_CMD;
            r_rd_addr <= bus.in_req_addr;
          end else if (r_count != '0) r_state <= WR_CMD;
        end
        RD_CMD: begin
          if (bus.out_req_ready) begin
            r_state <= RD_WAIT;
            r_beat  <= '0;
          end
        end
        RD_WAIT: begin
          if (bus.out_resp_valid) begin
            r_beat <= r_beat + 1'b1;
            if (r_beat == BW'(READ_BEATS - 1)) r_state <= IDLE;
          end
        end
        WR_CMD:  if (bus.out_req_ready) r_state <= WR_DATA;
        WR_DATA: if (bus.out_req_data_ready) r_state <= IDLE;
        default: r_state <= IDLE;
      endcase
    end
  end
endmodule

// File: doc/mem_write_buffer.md
# mem_write_buffer

Posted-write buffer between the data-side cache and the memory arbiter. Accepts single-beat masked writes into a DEPTH-entry FIFO and acknowledges them immediately. Reads are forwarded only when no buffered write targets the same address, which keeps read-after-write ordering intact. A single downstream FSM issues one transaction at a time to the arbiter; reads take priority over draining writes.

## Interface
- DEPTH, 4: write FIFO entries (power of 2, ≥2)
- ADDR_BITS, `MEM_ADDR_BITS: memory address width
- DATA_BITS, `MEM_DATA_BITS: data beat width; mask width is DATA_BITS/8
- READ_BEATS, 4: response beats per read
- clk  input  1  clock, all state on rising edge
- reset  input  1  asynchronous, active-low (0 = in reset)
- in_req_valid  input  1  upstream command valid
- in_req_ready  output  1  upstream command accepted
- in_req_rw  input  1  1 = write, 0 = read
- in_req_addr  input  ADDR_BITS  command address
- in_req_data_valid  input  1  write data valid
- in_req_data_ready  output  1  write data accepted (equals in_req_ready for writes)
- in_req_data_bits  input  DATA_BITS  write data
- in_req_data_mask  input  DATA_BITS/8  byte enables
- in_resp_valid  output  1  read response beat to upstream
- in_resp_data  output  DATA_BITS  read response data (wire from out_resp_data)
- out_req_valid  output  1  downstream command valid
- out_req_ready  input  1  downstream command accepted
- out_req_rw  output  1  downstream command type
- out_req_addr  output  ADDR_BITS  downstream address
- out_req_data_valid  output  1  downstream write data valid
- out_req_data_ready  input  1  downstream write data accepted
- out_req_data_bits  output  DATA_BITS  downstream write data
- out_req_data_mask  output  DATA_BITS/8  downstream byte enables
- out_resp_valid  input  1  downstream response beat
- out_resp_data  input  DATA_BITS  downstream response data
- wb_empty  output  1  FIFO empty and FSM in IDLE (fence/flush indicator)

## Operation
- FIFO entry holds {addr, data, mask}. Head pointer, tail pointer and count are registered. Count is ADDR-independent, width clog2(DEPTH)+1.
- Write accept: in_req_valid & in_req_rw & in_req_data_valid & count<DEPTH. When all hold, in_req_ready = in_req_data_ready = 1, the entry is pushed at tail, and tail wraps mod DEPTH.
- No partial write handshakes. Command and data are taken in the same cycle or not at all.
- Read accept requires all of:
  - in_req_valid & ~in_req_rw
  - state==IDLE
  - no valid FIFO entry whose addr equals in_req_addr
- On read accept, the address is latched and the FSM moves to RD_CMD. On a conflict the read waits and the FSM drains writes until the conflict clears.
- FSM states:
  - IDLE: on read accept, go to RD_CMD. Otherwise, if count>0, go to WR_CMD.
  - RD_CMD: out_req_valid=1, rw=0, addr=latched. When out_req_ready, go to RD_WAIT and clear the beat counter.
  - RD_WAIT: in_resp_valid=out_resp_valid and each beat increments the counter. On the READ_BEATS-th beat, return to IDLE.
  - WR_CMD: out_req_valid=1, rw=1, addr=head.addr. When out_req_ready, go to WR_DATA.
  - WR_DATA: out_req_data_valid=1, bits/mask from head. When out_req_data_ready, pop head and return to IDLE.
- Head entry stays in the FIFO until popped, so the conflict check covers an entry that is in flight.
- out_resp_valid outside RD_WAIT is ignored (in_resp_valid=0).
- Push and pop in the same cycle leave count unchanged.
- Full: writes stall while draining continues.
- Empty: IDLE holds and wb_empty=1.

## Timing
- While reset=0: FIFO cleared, pointers and count 0, FSM in IDLE, beat counter 0. In reset, all outputs are 0 except in_resp_data (wire). After reset, wb_empty=1.
- Asserting reset mid-transaction abandons the downstream transaction immediately. Buffered writes are lost.
- in_req_ready is combinational from inputs plus registered state. Out-side valids are decoded from registered state only.
- Write: accepted in cycle t, IDLE observes count>0 in t+1, out_req_valid (WR_CMD) in t+2 if the FSM was idle and no read is accepted in t+1.
- Read: accepted in cycle t, out_req_valid in t+1.
- Minimum write drain: 2 cycles per entry with ready tied high, plus 1 cycle in IDLE.
- Read with READ_BEATS=4 and responses on consecutive cycles: RD_CMD 1 cycle, then 4 RD_WAIT beats, then IDLE.
- Downstream valids hold stable until their handshake completes.

## Test plan
- Single write 0x100 (data 0xA5.., mask 0xFFFF), out ready tied 1 -> in_req_ready=1 same cycle. Out sees rw=1 addr 0x100 at t+2, then data/mask at t+3. wb_empty=1 at t+4.
- Fill with 4 writes while out_req_ready=0 -> 5th write sees in_req_ready=0. Release ready -> drain in order 0,1,2,3, count wraps correctly, 5th accepted once count=3.
- Buffer writes to 0x200 and 0x300, then read 0x200 -> read stalls until the 0x200 entry pops, then issues. A read to 0x400 issued instead goes out before the pending writes.
- Read 0x40 with 4 response beats D0..D3 -> in_resp_valid pulses exactly 4 times with matching data. A stray out_resp_valid in IDLE is not forwarded.
- Assert reset during WR_DATA with 3 entries buffered -> all outputs 0 immediately. After release, wb_empty=1 and no downstream request issues.
- Push and pop in the same cycle at count=2 -> count stays 2 and data order is preserved.
